mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single shared memory port.
// One access per two cycles; data wins ties unless fetch has starved STARVE_MAX times.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_r,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_r_q, mem_r_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  logic in_resp, if_wait, dm_elig, grant_dm, grant_if, grant;

  // In RESPOND the owner's req is its completed request, so only the other side is eligible.
  assign in_resp  = (state_q == S_RESPOND);
  assign if_wait  = if_req && !(in_resp && owner_q == OWN_IF);
  assign dm_elig  = dm_req && !(in_resp && owner_q == OWN_DM);
  assign grant_dm = dm_elig && !(if_wait && starve_q == STARVE_LIM);
  assign grant_if = if_wait && !grant_dm;
  assign grant    = (state_q == S_IDLE || in_resp) && (grant_dm || grant_if);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_r_d     = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE, S_RESPOND: begin
        if (grant) begin
          state_d  = S_ACCESS;
          owner_d  = grant_dm ? OWN_DM : OWN_IF;
          mem_r_d  = grant_if || !dm_we;
          mem_wr_d = grant_dm && dm_we;
          if (grant_dm) begin
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_wait && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
          end else begin
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_RESPOND;
        if (owner_q == OWN_IF) begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end else begin
          dm_ack_d = 1'b1;
          if (!mem_wr_q) dm_rdata_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      mem_r_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_r_q     <= mem_r_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_r     = mem_r_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req && !if_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple word-addressed memory model.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk, rst;
  logic          if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_r, mem_wr, stall_if;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_r(mem_r), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[12'h010] = 16'hA5A5;
    mem[12'h020] = 16'hBEEF;
    mem[12'h030] = 16'hC0DE;
    mem[12'h040] = 16'h4444;
    mem[12'h050] = 16'h5555;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    rst = 0;
    #1 rst = 1;
    #1;
    chk("rst_outs", {mem_r, mem_wr, if_ack, dm_ack, stall_if}, 5'b0);
    chk("rst_addr", mem_addr, 12'h000);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
    tick();
    rst = 0;

    // lone fetch
    if_req = 1; if_addr = 12'h010;
    #1 chk("fetch_stall_wait", stall_if, 1'b1);
    tick();
    chk("fetch_c1_rw", {mem_r, mem_wr}, 2'b10);
    chk("fetch_c1_addr", mem_addr, 12'h010);
    tick();
    chk("fetch_c2_ack", {if_ack, dm_ack, mem_r}, 3'b100);
    chk("fetch_c2_rdata", if_rdata, 16'hA5A5);
    if_req = 0;
    tick();
    chk("fetch_c3_ack", if_ack, 1'b0);
    chk("fetch_c3_stall", stall_if, 1'b0);

    // data write then read-back
    dm_req = 1; dm_we = 1; dm_addr = 12'h0FF; dm_wdata = 16'h1234;
    tick();
    chk("wr_c1_rw", {mem_r, mem_wr}, 2'b01);
    chk("wr_c1_addr", mem_addr, 12'h0FF);
    chk("wr_c1_wdata", mem_wdata, 16'h1234);
    tick();
    chk("wr_c2_ack", {dm_ack, if_ack, mem_wr}, 3'b100);
    chk("wr_c2_rdata_held", dm_rdata, 16'h0000);
    dm_req = 0;
    tick();
    chk("wr_c3_idle", {dm_ack, mem_r, mem_wr}, 3'b000);
    chk("idle_addr_hold", mem_addr, 12'h0FF);
    dm_req = 1; dm_we = 0;
    tick();
    chk("rd_c1_rw", {mem_r, mem_wr}, 2'b10);
    tick();
    chk("rd_c2_ack", dm_ack, 1'b1);
    chk("rd_c2_rdata", dm_rdata, 16'h1234);
    chk("if_rdata_held", if_rdata, 16'hA5A5);
    dm_req = 0;
    tick();

    // contention, both held: DM wins from IDLE, then alternation with no IDLE gap
    if_req = 1; if_addr = 12'h030; dm_req = 1; dm_we = 0; dm_addr = 12'h020;
    tick();
    chk("ct_e1_dm_addr", {mem_r, mem_addr}, {1'b1, 12'h020});
    chk("ct_e1_stall", stall_if, 1'b1);
    tick();
    chk("ct_e2_dm_ack", {dm_ack, if_ack}, 2'b10);
    chk("ct_e2_dm_rdata", dm_rdata, 16'hBEEF);
    chk("ct_e2_stall", stall_if, 1'b1);
    tick();
    chk("ct_e3_if_access", {mem_r, mem_addr}, {1'b1, 12'h030});
    chk("ct_e3_stall", stall_if, 1'b1);
    tick();
    chk("ct_e4_if_ack", {if_ack, dm_ack}, 2'b10);
    chk("ct_e4_if_rdata", if_rdata, 16'hC0DE);
    chk("ct_e4_stall", stall_if, 1'b0);
    tick();
    chk("ct_e5_dm_access", {mem_r, mem_addr}, {1'b1, 12'h020});
    tick();
    chk("ct_e6_dm_ack", dm_ack, 1'b1);
    dm_req = 0;
    tick();
    chk("ct_e7_if_access", {mem_r, mem_addr}, {1'b1, 12'h030});
    tick();
    chk("ct_e8_if_ack", if_ack, 1'b1);
    if_req = 0;
    tick();

    // starvation: three DM wins over a waiting fetch, then fetch is forced
    dm_addr = 12'h020; if_addr = 12'h030;
    for (int k = 0; k < 3; k++) begin
      if_req = 1; dm_req = 1;
      tick();
      chk("sv_dm_win", {mem_r, mem_addr}, {1'b1, 12'h020});
      if_req = 0;
      tick();
      chk("sv_dm_ack", {dm_ack, if_ack}, 2'b10);
      dm_req = 0;
      tick();
    end
    if_req = 1; dm_req = 1;
    tick();
    chk("sv_if_forced", {mem_r, mem_addr}, {1'b1, 12'h030});
    tick();
    chk("sv_if_ack", {if_ack, dm_ack}, 2'b10);
    if_req = 0;
    tick();
    chk("sv_dm_b2b", {mem_r, mem_addr}, {1'b1, 12'h020});
    tick();
    chk("sv_dm_ack2", dm_ack, 1'b1);
    dm_req = 0;
    tick();

    // requester drops during ACCESS: ack still pulses
    if_req = 1; if_addr = 12'h040;
    tick();
    if_req = 0;
    tick();
    chk("drop_ack", if_ack, 1'b1);
    chk("drop_rdata", if_rdata, 16'h4444);
    tick();

    // reset in the middle of ACCESS(IF)
    if_req = 1; if_addr = 12'h050;
    tick();
    chk("rm_access", mem_r, 1'b1);
    #2 rst = 1;
    #1;
    chk("rm_outs_zero", {mem_r, mem_wr, if_ack, dm_ack}, 4'b0);
    chk("rm_addr_zero", {mem_addr, mem_wdata}, 28'h0);
    chk("rm_rdata_zero", {if_rdata, dm_rdata}, 32'h0);
    tick();
    chk("rm_no_ack", if_ack, 1'b0);
    rst = 0;
    #1 chk("rm_released_idle", mem_r, 1'b0);
    tick();
    chk("rm_rearb", {mem_r, mem_addr}, {1'b1, 12'h050});
    tick();
    chk("rm_ack", {if_ack, if_rdata}, {1'b1, 16'h5555});
    if_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
